// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b memory-side types and eviction buffer states
package lc3b_types;

  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [15:0]  lc3b_pmem_addr;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    MEM_READ = 2'd2,
    DRAIN    = 2'd3
  } evict_state_e;

endpackage

// File: rtl/l2_eviction_buffer.sv
// rtl/l2_eviction_buffer.sv - one-entry write-back buffer between L2 and physical memory
module l2_eviction_buffer
  import lc3b_types::*;
#(
  parameter int LINE_BITS   = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 l2_read,
  input  logic                 l2_write,
  input  lc3b_pmem_addr        l2_address,
  input  logic [LINE_BITS-1:0] l2_wdata,
  output logic                 l2_resp,
  output logic [LINE_BITS-1:0] l2_rdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output lc3b_pmem_addr        pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic                 pmem_resp,
  input  logic [LINE_BITS-1:0] pmem_rdata
);

  // Buffered entry
  logic                 r_valid;
  lc3b_pmem_addr        r_addr;
  logic [LINE_BITS-1:0] r_data;

  // FSM state and registered outputs
  evict_state_e         r_state;
  logic                 r_l2_resp;
  logic [LINE_BITS-1:0] r_l2_rdata;
  logic                 r_pmem_read;
  logic                 r_pmem_write;
  lc3b_pmem_addr        r_pmem_address;
  logic [LINE_BITS-1:0] r_pmem_wdata;

  // Decisions taken in IDLE; a simultaneous read+write is handled as a write
  logic w_idle;
  logic w_match;
  logic w_is_read;
  logic w_capture;
  logic w_evict;
  logic w_rd_hit;
  logic w_rd_miss;
  logic w_flush;
  logic w_start_drain;
  logic w_drain_done;
  logic w_read_done;

  assign w_idle        = (r_state == IDLE);
  assign w_match       = r_valid && (r_addr[15:OFFSET_BITS] == l2_address[15:OFFSET_BITS]);
  assign w_is_read     = l2_read && !l2_write;
  assign w_capture     = w_idle && l2_write && (!r_valid || w_match);
  assign w_evict       = w_idle && l2_write && r_valid && !w_match;
  assign w_rd_hit      = w_idle && w_is_read && w_match;
  assign w_rd_miss     = w_idle && w_is_read && !w_match;
  assign w_flush       = w_idle && !l2_write && !l2_read && r_valid;
  assign w_start_drain = w_evict || w_flush;
  assign w_drain_done  = (r_state == DRAIN) && pmem_resp;
  assign w_read_done   = (r_state == MEM_READ) && pmem_resp;

  // Buffered entry: a write to an empty or matching entry overwrites it, a finished drain empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_addr  <= l2_address;
      r_data  <= l2_wdata;
    end else if (w_drain_done) begin
      r_valid <= 1'b0;
    end
  end

  // Control FSM with registered L2 and memory-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_l2_resp      <= 1'b0;
      r_l2_rdata     <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      r_l2_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_l2_resp <= 1'b1;
            r_state   <= ACK;
          end else if (w_rd_hit) begin
            r_l2_rdata <= r_data;
            r_l2_resp  <= 1'b1;
            r_state    <= ACK;
          end else if (w_rd_miss) begin
            // The buffered line is left in place; reads bypass the pending write
            r_pmem_read    <= 1'b1;
            r_pmem_address <= l2_address;
            r_state        <= MEM_READ;
          end else if (w_start_drain) begin
            r_pmem_write   <= 1'b1;
            r_pmem_address <= r_addr;
            r_pmem_wdata   <= r_data;
            r_state        <= DRAIN;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        MEM_READ: begin
          if (w_read_done) begin
            r_pmem_read <= 1'b0;
            r_l2_rdata  <= pmem_rdata;
            r_l2_resp   <= 1'b1;
            r_state     <= ACK;
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_pmem_write <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign l2_resp      = r_l2_resp;
  assign l2_rdata     = r_l2_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_l2_eviction_buffer.sv
// tb/tb_l2_eviction_buffer.sv - scoreboard bench for l2_eviction_buffer
module tb_l2_eviction_buffer;

  localparam int MEM_LAT = 3;

  localparam logic [127:0] D1 = 128'h1111_0001_1111_0002_1111_0003_1111_0004;
  localparam logic [127:0] D2 = 128'h2222_a5a5_2222_5a5a_2222_0f0f_2222_f0f0;
  localparam logic [127:0] D3 = 128'h3333_3333_dead_beef_3333_3333_cafe_f00d;
  localparam logic [127:0] D4 = 128'h4444_0123_4567_89ab_cdef_4444_4444_0000;
  localparam logic [127:0] D5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] D6 = 128'h6666_1234_6666_5678_6666_9abc_6666_def0;
  localparam logic [127:0] D7 = 128'h7777_fedc_ba98_7654_3210_7777_0000_ffff;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         l2_read = 1'b0;
  logic         l2_write = 1'b0;
  logic [15:0]  l2_address = '0;
  logic [127:0] l2_wdata = '0;
  logic         l2_resp;
  logic [127:0] l2_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [127:0] pmem_rdata = '0;

  logic [127:0] mem_line = '0;
  logic         mem_hold = 1'b0;

  typedef struct {
    logic         is_read;
    logic [127:0] data;
  } l2_exp_t;

  typedef struct {
    logic         is_write;
    logic [15:0]  addr;
    logic [127:0] data;
  } pm_exp_t;

  l2_exp_t l2_q[$];
  pm_exp_t pm_q[$];

  int errors = 0;
  int checks = 0;
  int both_err = 0;

  l2_eviction_buffer #(.LINE_BITS(128), .OFFSET_BITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_resp      (l2_resp),
    .l2_rdata     (l2_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Memory model: answers any request MEM_LAT cycles after it appears, unless held off
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if ((pmem_read || pmem_write) && !mem_hold) begin
        cnt++;
        if (cnt >= MEM_LAT) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? mem_line : '0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT answers L2 or starts a memory request
  initial begin : monitor
    logic    prev_act;
    logic    act;
    l2_exp_t e;
    pm_exp_t p;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_act = 1'b0;
      end else begin
        if (l2_resp) begin
          if (l2_q.size() == 0) begin
            fail_event("unexpected_l2_resp");
          end else begin
            e = l2_q.pop_front();
            check("resp_kind_is_write", l2_write, !e.is_read);
            if (e.is_read) check("l2_rdata", l2_rdata, e.data);
          end
        end
        if (pmem_read && pmem_write) both_err++;
        act = pmem_read || pmem_write;
        if (act && !prev_act) begin
          if (pm_q.size() == 0) begin
            fail_event("unexpected_pmem_request");
          end else begin
            p = pm_q.pop_front();
            check("pmem_kind_is_write", pmem_write, p.is_write);
            check("pmem_address", pmem_address, p.addr);
            if (p.is_write) check("pmem_wdata", pmem_wdata, p.data);
          end
        end
        prev_act = act;
      end
    end
  end

  // Issue one L2 request (called at posedge+1) and hold it until l2_resp
  task automatic issue(input string name, input logic wr, input logic rd,
                       input logic [15:0] addr, input logic [127:0] wdata,
                       input logic [127:0] exp_rdata, input int exp_n, input int exp_since);
    int n;
    int since;
    int pm_seen;
    bit got;
    n = 0;
    since = -1;
    pm_seen = 0;
    got = 1'b0;
    l2_q.push_back('{is_read: (rd && !wr), data: exp_rdata});
    l2_address = addr;
    l2_wdata   = wdata;
    l2_write   = wr;
    l2_read    = rd;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (since >= 0) since++;
      if (pmem_read || pmem_write) pm_seen++;
      if (l2_resp) got = 1'b1;
      else if (pmem_resp) since = 0;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no l2_resp within %0d cycles", name, n);
    end else begin
      if (exp_n > 0) begin
        check({name, "_latency"}, n, exp_n);
        check({name, "_no_pmem"}, pm_seen, 0);
      end
      if (exp_since > 0) check({name, "_after_pmem_resp"}, since, exp_since);
    end
    @(posedge clk);
    #1;
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  // Wait for all expected memory traffic to finish, then confirm the memory side goes quiet
  task automatic wait_drained(input string name);
    int n;
    int act;
    n = 0;
    while ((pm_q.size() != 0 || pmem_read || pmem_write) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pmem_ops_done"}, pm_q.size(), 0);
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (pmem_read || pmem_write) act++;
    end
    check({name, "_pmem_quiet"}, act, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int n;
    int act;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_l2_resp", l2_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_l2_rdata", l2_rdata, '0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write into empty buffer, then an idle flush writes it out
    pm_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D1});
    issue("wr_empty", 1'b1, 1'b0, 16'h1230, D1, '0, 2, 0);
    wait_drained("flush_idle");

    // Read hit on another byte of the buffered line
    pm_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D1});
    issue("wr_for_hit", 1'b1, 1'b0, 16'h1230, D1, '0, 2, 0);
    issue("rd_hit", 1'b0, 1'b1, 16'h1238, '0, D1, 2, 0);
    wait_drained("after_hit");

    // Read miss bypasses the buffered line, which is drained afterwards
    mem_line = D2;
    pm_q.push_back('{is_write: 1'b0, addr: 16'h4000, data: '0});
    pm_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D1});
    issue("wr_for_miss", 1'b1, 1'b0, 16'h1230, D1, '0, 2, 0);
    issue("rd_miss", 1'b0, 1'b1, 16'h4000, '0, D2, 0, 1);
    wait_drained("after_miss");

    // Conflicting write evicts the buffered line first
    pm_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D1});
    pm_q.push_back('{is_write: 1'b1, addr: 16'h5670, data: D4});
    issue("wr_first", 1'b1, 1'b0, 16'h1230, D1, '0, 2, 0);
    issue("wr_conflict", 1'b1, 1'b0, 16'h5670, D4, '0, 0, 2);
    wait_drained("after_conflict");

    // Same-line writes coalesce into one drain carrying the newest data
    pm_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D3});
    issue("wr_old", 1'b1, 1'b0, 16'h1230, D1, '0, 2, 0);
    issue("wr_coalesce", 1'b1, 1'b0, 16'h1230, D3, '0, 2, 0);
    wait_drained("after_coalesce");

    // Simultaneous read and write is treated as a write
    pm_q.push_back('{is_write: 1'b1, addr: 16'h2220, data: D6});
    issue("rw_both", 1'b1, 1'b1, 16'h2220, D6, '0, 2, 0);
    wait_drained("after_both");

    // Reset in the middle of a drain whose response never arrives
    mem_hold = 1'b1;
    pm_q.push_back('{is_write: 1'b1, addr: 16'h1230, data: D5});
    issue("wr_pre_reset", 1'b1, 1'b0, 16'h1230, D5, '0, 2, 0);
    n = 0;
    while (!pmem_write && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_started_before_reset", pmem_write, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_pmem_write", pmem_write, 1'b0);
    check("mid_rst_pmem_read", pmem_read, 1'b0);
    check("mid_rst_l2_resp", l2_resp, 1'b0);
    check("mid_rst_pmem_address", pmem_address, '0);
    check("mid_rst_pmem_wdata", pmem_wdata, '0);
    check("mid_rst_l2_rdata", l2_rdata, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_hold = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (pmem_read || pmem_write) act++;
    end
    check("post_rst_no_pmem", act, 0);
    @(posedge clk);
    #1;
    // The discarded line must not hit: this read goes to memory
    mem_line = D7;
    pm_q.push_back('{is_write: 1'b0, addr: 16'h1230, data: '0});
    issue("rd_after_rst", 1'b0, 1'b1, 16'h1230, '0, D7, 0, 1);
    wait_drained("after_reset");

    check("pmem_read_write_overlap", both_err, 0);
    check("l2_expect_left", l2_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
